// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared types and constants for the BCD conversion scheduler and its
// double-dabble engine.
package bcd_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                    BCD_W       = 8;
    localparam int                    NIBBLE_W    = 4;
    localparam logic [NIBBLE_W-1:0]   ADD3_THRESH = 4'd5;
    localparam logic [NIBBLE_W-1:0]   ADD3_VAL    = 4'd3;
    localparam logic [BCD_W-1:0]      BCD_MAX     = 8'h99;
    localparam int                    BIN_MAX     = 99;

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// Request/result bundle between the display-side requesters and the
// shared BCD conversion scheduler.
//
// Handshake: req[i] is a level request that the requester holds high until
// it sees ack[i]. ack[i] is a single-cycle pulse meaning bcd_flat slice i
// has just been rewritten; the requester should drop req[i] in that cycle
// unless it wants another conversion in the next round-robin round.
// bin_flat slice i is sampled only on the clock edge that grants channel i.
interface bcd_conv_scheduler_if
    import bcd_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int BIN_W = 7,
    parameter int CH_W  = $clog2(N_CH)
);
    logic [N_CH-1:0]       req;
    logic [N_CH*BIN_W-1:0] bin_flat;
    logic [N_CH-1:0]       ack;
    logic [N_CH*BCD_W-1:0] bcd_flat;
    logic                  busy;
    logic [CH_W-1:0]       cur_ch;
    logic [N_CH-1:0]       range_err;
    state_t                state_dbg;

    modport master (
        output req, bin_flat,
        input  ack, bcd_flat, busy, cur_ch, range_err, state_dbg
    );

    modport slave (
        input  req, bin_flat,
        output ack, bcd_flat, busy, cur_ch, range_err, state_dbg
    );
endinterface

// File: rtl/bcd_conv_scheduler_engine.sv
// Iterative double-dabble datapath: load a binary value, then one
// add-3-and-shift step per clock. After BIN_W steps the two BCD digits
// sit in the top byte of the shift register.
module bcd_dabble_engine
    import bcd_pkg::*;
#(
    parameter int BIN_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd_out
);
    localparam int SR_W = BIN_W + BCD_W;

    logic [SR_W-1:0] sreg;
    logic [SR_W-1:0] corrected;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next shift
    always_comb begin
        corrected = sreg;
        for (int d = 0; d < BCD_W / NIBBLE_W; d++) begin
            if (sreg[BIN_W + d*NIBBLE_W +: NIBBLE_W] >= ADD3_THRESH)
                corrected[BIN_W + d*NIBBLE_W +: NIBBLE_W] =
                    sreg[BIN_W + d*NIBBLE_W +: NIBBLE_W] + ADD3_VAL;
        end
    end

    // Shift register: load the binary operand, or correct-and-shift by one
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sreg <= '0;
        else if (load)
            sreg <= {{BCD_W{1'b0}}, bin};
        else if (step)
            sreg <= corrected << 1;
    end

    // Digits overflowing past the tens place fall off the top of sreg
    assign bcd_out = sreg[SR_W-1 -: BCD_W];
endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one double-dabble engine between N_CH
// requesters; keeps a registered BCD result per channel for the display mux.
// Optional build macro BCD_RANGE_CHECK_EN: values above 99 store 8'h99 and
// set a sticky per-channel range_err flag.
module bcd_conv_scheduler
    import bcd_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int BIN_W = 7,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_conv_scheduler_if.slave  bus
);
    localparam int              CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t                 state;
    logic [CH_W-1:0]        rr_ptr;
    logic [CH_W-1:0]        cur_ch_q;
    logic [CNT_W-1:0]       cnt;
    logic [N_CH-1:0]        ack_q;
    logic [N_CH*BCD_W-1:0]  bcd_q;

    logic                   grant_found;
    logic [CH_W-1:0]        grant_ch;
    logic [BIN_W-1:0]       bin_arr [N_CH];
    logic [BIN_W-1:0]       grant_bin;
    logic [BCD_W-1:0]       eng_bcd;
    logic [BCD_W-1:0]       result;
    logic                   eng_load;
    logic                   eng_step;

    for (genvar g = 0; g < N_CH; g++) begin : g_bin
        assign bin_arr[g] = bus.bin_flat[g*BIN_W +: BIN_W];
    end

    // Arbiter: first pending request at or above rr_ptr, wrapping around
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!grant_found && bus.req[CH_W'((int'(rr_ptr) + i) % N_CH)]) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'((int'(rr_ptr) + i) % N_CH);
            end
        end
    end

    assign grant_bin = bin_arr[grant_ch];
    assign eng_load  = (state == IDLE) && grant_found;
    assign eng_step  = (state == SHIFT);

    bcd_dabble_engine #(.BIN_W(BIN_W)) u_engine (
        .clk     (clk),
        .reset   (reset),
        .load    (eng_load),
        .step    (eng_step),
        .bin     (grant_bin),
        .bcd_out (eng_bcd)
    );

`ifdef BCD_RANGE_CHECK_EN
    logic            grant_oor;
    logic            oor_q;
    logic [N_CH-1:0] rerr_q;

    assign grant_oor     = (int'(grant_bin) > BIN_MAX);
    assign result        = oor_q ? BCD_MAX : eng_bcd;
    assign bus.range_err = rerr_q;
`else
    assign result        = eng_bcd;
    assign bus.range_err = '0;
`endif

    // Scheduler FSM: grant, run BIN_W engine steps, write result and ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cur_ch_q <= '0;
            cnt      <= '0;
            ack_q    <= '0;
            bcd_q    <= '0;
`ifdef BCD_RANGE_CHECK_EN
            oor_q    <= 1'b0;
            rerr_q   <= '0;
`endif
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        cur_ch_q <= grant_ch;
                        cnt      <= '0;
`ifdef BCD_RANGE_CHECK_EN
                        oor_q    <= grant_oor;
`endif
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= DONE;
                end
                DONE: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (cur_ch_q == CH_W'(i)) begin
                            bcd_q[i*BCD_W +: BCD_W] <= result;
                            ack_q[i]                <= 1'b1;
`ifdef BCD_RANGE_CHECK_EN
                            rerr_q[i]               <= oor_q;
`endif
                        end
                    end
                    rr_ptr <= (cur_ch_q == CH_W'(N_CH - 1)) ? '0 : cur_ch_q + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.bcd_flat  = bcd_q;
    assign bus.busy      = (state != IDLE);
    assign bus.cur_ch    = cur_ch_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: directed scenarios plus randomized request
// batches, checked by a queue-based scoreboard against an arithmetic model.
module tb_bcd_conv_scheduler;
    import bcd_pkg::*;

    localparam int N_CH  = 4;
    localparam int BIN_W = 7;
    localparam int W     = 28;  // {ack cycle[15:0], ch[2:0], err, bcd[7:0]}
`ifdef BCD_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_conv_scheduler_if #(.N_CH(N_CH), .BIN_W(BIN_W)) bus ();

    bcd_conv_scheduler #(.N_CH(N_CH), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0]       exp_q[$];
    int                 total = 0;
    int                 bad   = 0;
    logic [7:0]         bcd_model [N_CH];
    logic [N_CH-1:0]    err_model;
    logic [BIN_W-1:0]   bin_v [N_CH];
    int                 model_rr = 0;
    bit                 auto_drop = 1'b1;
    logic [W-1:0]       mon_e;
    int                 mon_ch;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_bcd(input int v);
        if (RANGE_EN && v > 99) return 8'h99;
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic ref_err(input int v);
        return RANGE_EN && (v > 99);
    endfunction

    function automatic int next_req(input logic [N_CH-1:0] mask, input int ptr);
        for (int i = 0; i < N_CH; i++)
            if (mask[(ptr + i) % N_CH]) return (ptr + i) % N_CH;
        return -1;
    endfunction

    function automatic logic [N_CH*8-1:0] model_flat();
        logic [N_CH*8-1:0] f;
        for (int i = 0; i < N_CH; i++) f[i*8 +: 8] = bcd_model[i];
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle step; requesters drop req on their own ack when auto_drop is set
    task automatic tick();
        @(negedge clk);
        #2;
        if (auto_drop) bus.req = bus.req & ~bus.ack;
    endtask

    // Raise requests for mask with bin_v values; predict nconv results in
    // round-robin order, each taking 9 clocks from an idle scheduler
    task automatic issue(input logic [N_CH-1:0] mask, input int nconv);
        int unsigned c;
        int idx;
        c = cyc;
        for (int k = 0; k < N_CH; k++) bus.bin_flat[k*BIN_W +: BIN_W] = bin_v[k];
        for (int k = 0; k < nconv; k++) begin
            idx = next_req(mask, model_rr);
            exp_q.push_back({16'(c + 9*(k + 1)), 3'(idx), ref_err(int'(bin_v[idx])),
                             ref_bcd(int'(bin_v[idx]))});
            model_rr = (idx + 1) % N_CH;
        end
        bus.req = bus.req | mask;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < N_CH; i++) bcd_model[i] = 8'h00;
            err_model = '0;
        end else if (bus.ack != '0) begin
            check("ack_onehot", 32'($onehot(bus.ack)), 1);
            mon_ch = 0;
            for (int i = N_CH - 1; i >= 0; i--) if (bus.ack[i]) mon_ch = i;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack on ch %0d expected none", mon_ch);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_ch", mon_ch, 32'(mon_e[11:9]));
                check("ack_cycle", 32'(cyc[15:0]), 32'(mon_e[27:12]));
                bcd_model[mon_e[11:9]] = mon_e[7:0];
                err_model[mon_e[11:9]] = mon_e[8];
                check("bcd_flat", bus.bcd_flat, model_flat());
                check("range_err", 32'(bus.range_err), 32'(err_model));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int bcnt;
        int chs [5];
        int vals [5];
        logic [N_CH-1:0] mask;
        chs  = '{1, 2, 3, 2, 3};
        vals = '{0, 9, 10, 59, 99};

        reset    = 1'b1;
        bus.req  = '0;
        bus.bin_flat = '0;
        for (int i = 0; i < N_CH; i++) bin_v[i] = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_bcd", bus.bcd_flat, 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cur_ch", 32'(bus.cur_ch), 0);
        check("rst_range_err", 32'(bus.range_err), 0);
        reset = 1'b0;
        tick();

        // Single conversion, busy window, bin sampled only at grant
        bin_v[0] = 7'd42;
        issue(4'b0001, 1);
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.busy) bcnt++;
            if (i == 0) check("cur_ch_busy", 32'(bus.cur_ch), 0);
            if (i == 2) bus.bin_flat[BIN_W-1:0] = 7'd99;
        end
        check("busy_cycles", bcnt, 8);
        wait_drain();

        // Edge values, one channel at a time
        for (int t = 0; t < 5; t++) begin
            bin_v[chs[t]] = 7'(vals[t]);
            issue(4'(1 << chs[t]), 1);
            wait_drain();
        end

        // All four at once
        bin_v[0] = 7'd59; bin_v[1] = 7'd23; bin_v[2] = 7'd7; bin_v[3] = 7'd0;
        issue(4'b1111, 4);
        wait_drain();

        // Two requesters held high continuously alternate slots
        auto_drop = 1'b0;
        bin_v[0] = 7'd88; bin_v[2] = 7'd16;
        issue(4'b0101, 4);
        repeat (36) @(negedge clk);
        bus.req = '0;
        auto_drop = 1'b1;
        wait_drain();

        // Out-of-range value, then an in-range one on the same channel
        bin_v[1] = 7'd127;
        issue(4'b0010, 1);
        wait_drain();
        bin_v[1] = 7'd5;
        issue(4'b0010, 1);
        wait_drain();

        // Reset in the 4th SHIFT cycle of ch1 discards the conversion
        bin_v[1] = 7'd64;
        issue(4'b0010, 1);
        repeat (4) tick();
        reset = 1'b1;
        bus.req = '0;
        #1;
        check("mid_rst_ack", 32'(bus.ack), 0);
        check("mid_rst_bcd", bus.bcd_flat, 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_range_err", 32'(bus.range_err), 0);
        model_rr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        bin_v[1] = 7'd37;
        issue(4'b0010, 1);
        wait_drain();

        // Randomized batches
        for (int it = 0; it < 12; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < N_CH; k++)
                bin_v[k] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(100, 127))
                                                        : 7'($urandom_range(0, 99));
            issue(mask, $countones(mask));
            wait_drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
Shares one iterative shift-add-3 (double-dabble) binary-to-BCD engine between N_CH requesters in the alarm clock: time, alarm and timer hour/minute/second fields. It grants requesters round-robin and converts one bit per clock. Each channel's 2-digit BCD result is held in a per-channel register that feeds the seven-segment display mux.

Parameters:
N_CH, 4, number of requesting channels (2..8)
BIN_W, 7, binary input width per channel; legal range 0..99
CH_W, $clog2(N_CH), width of the channel index

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  N_CH  per-channel conversion request, level; held until ack
bin_flat  in  N_CH*BIN_W  channel i value at [i*BIN_W +: BIN_W]
ack  out  N_CH  one-clock pulse: channel i result updated
bcd_flat  out  N_CH*8  channel i BCD {tens,units} at [i*8 +: 8], registered
busy  out  1  high whenever state != IDLE
cur_ch  out  CH_W  channel being converted; valid while busy
range_err  out  N_CH  sticky per-channel out-of-range flag (feature only; tied 0 otherwise)

Behaviour:
- Reset (async, immediate): state=IDLE, ack=0, bcd_flat=0, busy=0, cur_ch=0, rr_ptr=0, range_err=0. An in-flight conversion is discarded with no ack and no register write.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if req!=0, grant the first set req bit searching upward from rr_ptr with wrap. On that edge: cur_ch<=winner; shift reg[BIN_W+7:0] <= {8'b0, bin of winner}; cnt<=0; go to SHIFT. If req==0, stay in IDLE.
- SHIFT, every edge: for each BCD nibble, if >=5 then +3; then shift the whole register left by 1; cnt++. Go to DONE at the edge where cnt==BIN_W-1, i.e. after exactly BIN_W shifts.
- DONE: bcd reg[cur_ch]<=shift reg[BIN_W+7:BIN_W]; ack[cur_ch]<=1 for one clock; rr_ptr<=cur_ch+1 (mod N_CH); go to IDLE.
- Latency: req sampled at edge k means ack is high from edge k+BIN_W+1 to k+BIN_W+2 (k+8 for the default). Throughput is one conversion per BIN_W+2 clocks.
- bin is sampled only at the grant edge; later changes do not affect the conversion in flight.
- If req drops after grant, the conversion still completes, acks and writes. If req drops before grant, nothing happens.
- Simultaneous requests are served in round-robin order; a requester that keeps req high gets one slot per round.
- Writes to one channel leave the other channels' bcd registers untouched.
- At most one ack bit is high in any cycle.

Optional Feature:
Macro BCD_RANGE_CHECK_EN.
- Defined: at grant, if bin>99, the stored result is 8'h99 and range_err[ch] is set. range_err[ch] clears on the next in-range conversion of that channel or on reset.
- Undefined: there is no check; the stored result is the low two digits, so 127 gives 8'h27. range_err is tied to 0.

Decomposition:
- Package bcd_pkg holds: the state enum (IDLE, SHIFT, DONE), BCD_W=8, NIBBLE_W=4, ADD3_THRESH=5, ADD3_VAL=3, BCD_MAX=8'h99.
- One sub-module, bcd_dabble_engine: load/step inputs, shift register and add-3 correction, exposing bcd_out. The scheduler keeps the arbiter, FSM, counter and result bank.

Test Plan:
- Reset, then req[0] with bin0=42 -> ack[0] pulses at edge +8; bcd_flat[7:0]=8'h42; busy high for 8 clocks.
- Edge values, one channel at a time: 0, 9, 10, 59, 99 -> 8'h00, 8'h09, 8'h10, 8'h59, 8'h99.
- req=4'b1111 in the same cycle with values 59, 23, 7, 0 -> acks in order ch0, ch1, ch2, ch3, spaced 9 clocks apart; all four registers are correct and never overwrite each other.
- req[0] and req[2] held high continuously -> grants alternate 0, 2, 0, 2; neither channel misses a slot.
- Assert reset during the 4th SHIFT cycle of ch1 -> outputs go to 0 immediately with no ack; after release, a fresh req[1]=37 gives 8'h37.
- bin=127: with BCD_RANGE_CHECK_EN gives 8'h99 and range_err[ch]=1, and a following bin=5 clears it; without the macro gives 8'h27 and range_err=0.
